pace_timing_ctrl: RTL and testbench
===================================

// Module: pace_timing_ctrl
// PURPOSE
//  Ventricular demand pacing scheduler (VVI-style), sitting between the sense front-end and the
//  LED_HEART/LED_PACE indicators in top. It runs one escape counter from the last event, inhibits
//  the pace on an intrinsic sense, and issues a pace pulse when the lower-rate interval expires.
//  It enforces a refractory window after every sensed or paced event.
// PARAMETERS
//  CNT_W     16    width of interval counter and config registers, in TICK units
//  LRI_DEF   1000  reset lower-rate interval in ticks (1000 ms = 60 bpm with a 1 ms TICK)
//  VRP_DEF   250   reset refractory period in ticks
//  PW_DEF    2     reset pace pulse width in ticks
//  HOLD      50    LED stretch length in ticks
// PORTS
//  CLK        in   1      system clock
//  RST        in   1      asynchronous, active-high reset
//  TICK       in   1      1-cycle timebase strobe from the prescaler
//  EN         in   1      1 = run scheduler; 0 = force IDLE
//  SENSE      in   1      1-cycle intrinsic beat strobe, synchronous to CLK
//  CFG_WE     in   1      config write strobe
//  CFG_LRI    in   CNT_W  lower-rate interval, in ticks
//  CFG_VRP    in   CNT_W  refractory period, in ticks
//  CFG_PW     in   CNT_W  pulse width, in ticks
//  PACE       out  1      pace stimulus, high for PW ticks
//  SENSED     out  1      1-cycle strobe for an accepted (non-refractory) sense
//  LED_HEART  out  1      stretched SENSED indicator
//  LED_PACE   out  1      stretched PACE-onset indicator
//  STATE      out  2      current state: IDLE=0, ALERT=1, PACING=2, REFRACT=3
//  CFG_ERR    out  1      sticky error flag; cleared by an accepted write or by RST
// BEHAVIOUR
//  Reset values: STATE=IDLE, cnt=0, all outputs 0, config = LRI_DEF/VRP_DEF/PW_DEF.
//  RST is asynchronous; when asserted mid-pulse, PACE drops immediately.
//  cnt counts TICKs since the last event, increments only on TICK, and saturates at all-ones.
//  IDLE:
//   - EN=1 -> ALERT, cnt=0.
//   - CFG_WE accepted only here, and only when PW < VRP < LRI and PW != 0.
//   - Rejected write: CFG_ERR=1, registers unchanged.
//  Any CFG_WE outside IDLE: ignored, CFG_ERR=1.
//  ALERT (sense window):
//   - SENSE -> next cycle SENSED=1 for 1 cycle, state REFRACT, cnt=0 (pace inhibited).
//   - TICK with cnt+1 == LRI -> next cycle PACE=1, state PACING, cnt=0.
//   - SENSE and expiry TICK in the same cycle: the sense wins, no pace.
//  PACING:
//   - PACE held high; SENSE ignored.
//   - TICK with cnt+1 == PW -> PACE=0, state REFRACT; cnt keeps counting from the pace onset.
//  REFRACT:
//   - SENSE ignored (no SENSED, no restart).
//   - TICK with cnt+1 == VRP -> ALERT.
//  Timing references:
//   - LRI and VRP are both measured from the event onset.
//   - Paced escape period = exactly LRI ticks, onset to onset.
//  EN=0 in any state -> IDLE on the next edge; PACE=0 and cnt=0 on that edge.
//  LED_PACE / LED_HEART:
//   - Set the cycle after PACE rises / SENSED pulses, held for HOLD ticks.
//   - A retrigger restarts the hold.
//  Latency: SENSE to SENSED is 1 cycle; expiry TICK to PACE rise is 1 cycle.
// STRUCTURE
//  Package pace_pkg:
//   - state encoding localparams (IDLE/ALERT/PACING/REFRACT);
//   - default interval constants.
//  Sub-module led_stretch (TICK-based retriggerable hold counter), instantiated twice, once per LED.
//  Top-level FSM, cnt and config registers stay in pace_timing_ctrl.
// TESTING
//  Bench setup: TICK every 4 CLK; config LRI=10, VRP=4, PW=2, HOLD=3 written in IDLE.
//  1 No SENSE, EN=1:
//    - PACE rises 10 ticks after entry and stays high 2 ticks.
//    - Pace onsets repeat every 10 ticks; LED_PACE high 3 ticks each.
//  2 SENSE at tick 6 of ALERT:
//    - SENSED 1 cycle later, STATE=3; no pace at tick 10.
//    - Next pace onset 10 ticks after the sense.
//  3 SENSE at tick 2 after a pace onset (REFRACT):
//    - no SENSED, LED_HEART stays 0;
//    - pace timing unchanged (next onset at tick 10).
//  4 SENSE in the same cycle as the expiry TICK:
//    - SENSED=1, PACE stays 0, STATE=3.
//  5 CFG write LRI=3, VRP=4 in IDLE -> CFG_ERR=1, old config retained.
//    CFG write during ALERT -> ignored, CFG_ERR=1.
//  6 Mid-pulse events:
//    - RST mid-PACE -> PACE=0 asynchronously, STATE=0, config restored to defaults.
//    - EN=0 mid-PACE -> PACE=0 on the next edge, STATE=0.

Source files
------------

// File: rtl/pace_pkg.sv
// Shared definitions for the demand pacing scheduler: FSM state encoding and reset-time intervals.
// Latency: n/a (types and constants only).
// Backpressure: n/a.
package pace_pkg;

  // Encoding is visible on the STATE port, so the values are fixed.
  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_ALERT   = 2'd1,
    ST_PACING  = 2'd2,
    ST_REFRACT = 2'd3
  } pace_state_e;

  // Reset-time intervals, in TICK units (1 ms TICK: 60 bpm lower rate).
  localparam int PACE_CNT_W   = 16;
  localparam int PACE_LRI_DEF = 1000;
  localparam int PACE_VRP_DEF = 250;
  localparam int PACE_PW_DEF  = 2;
  localparam int PACE_HOLD    = 50;

endpackage

// File: rtl/led_stretch.sv
// Retriggerable LED stretcher: a 1-cycle trig lights led on the next cycle and holds it for HOLD ticks.
// Latency: trig to led rise is 1 cycle; a new trig restarts the hold from zero.
// Backpressure: none; trig is a strobe and is never dropped.
// Ports:
//   clk, rst  clock and asynchronous active-high reset
//   tick      1-cycle timebase strobe
//   trig      1-cycle event strobe to stretch
//   led       stretched indicator
module led_stretch #(
  parameter int CNT_W = 16,
  parameter int HOLD  = 50
) (
  input  logic clk,
  input  logic rst,
  input  logic tick,
  input  logic trig,
  output logic led
);

  localparam logic [CNT_W-1:0] HOLD_C = CNT_W'(HOLD);

  logic             led_q, led_d;
  logic [CNT_W-1:0] hold_q, hold_d;

  always_comb begin
    led_d  = led_q;
    hold_d = hold_q;
    if (trig) begin
      led_d  = 1'b1;
      hold_d = '0;
    end else if (led_q && tick) begin
      // Ticks are counted only while lit; the tick in the trigger cycle itself is ignored.
      hold_d = hold_q + CNT_W'(1);
      if (hold_d == HOLD_C) begin
        led_d = 1'b0;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      led_q  <= 1'b0;
      hold_q <= '0;
    end else begin
      led_q  <= led_d;
      hold_q <= hold_d;
    end
  end

  assign led = led_q;

endmodule

// File: rtl/pace_timing_ctrl.sv
// VVI demand pacing scheduler: escape counter from the last event, sense inhibits pacing, pace on LRI expiry.
// Latency: SENSE to SENSED 1 cycle; expiry TICK to PACE rise 1 cycle; LEDs follow one cycle later.
// Backpressure: none; SENSE/TICK are strobes, config writes are accepted or flagged in CFG_ERR.
// Ports:
//   CLK, RST                   clock and asynchronous active-high reset
//   TICK, EN, SENSE            timebase strobe, run enable, intrinsic beat strobe
//   CFG_WE, CFG_LRI/VRP/PW     config write (accepted in IDLE only, needs 0 < PW < VRP < LRI)
//   PACE, SENSED               pace stimulus level, accepted-sense strobe
//   LED_HEART, LED_PACE        stretched sense / pace-onset indicators
//   STATE, CFG_ERR             FSM state (IDLE=0 ALERT=1 PACING=2 REFRACT=3), sticky config error
module pace_timing_ctrl
  import pace_pkg::*;
#(
  parameter int CNT_W   = PACE_CNT_W,
  parameter int LRI_DEF = PACE_LRI_DEF,
  parameter int VRP_DEF = PACE_VRP_DEF,
  parameter int PW_DEF  = PACE_PW_DEF,
  parameter int HOLD    = PACE_HOLD
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             TICK,
  input  logic             EN,
  input  logic             SENSE,
  input  logic             CFG_WE,
  input  logic [CNT_W-1:0] CFG_LRI,
  input  logic [CNT_W-1:0] CFG_VRP,
  input  logic [CNT_W-1:0] CFG_PW,
  output logic             PACE,
  output logic             SENSED,
  output logic             LED_HEART,
  output logic             LED_PACE,
  output logic [1:0]       STATE,
  output logic             CFG_ERR
);

  pace_state_e      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [CNT_W-1:0] lri_q, lri_d;
  logic [CNT_W-1:0] vrp_q, vrp_d;
  logic [CNT_W-1:0] pw_q, pw_d;
  logic             sensed_q, sensed_d;
  logic             pace_start_q, pace_start_d;
  logic             cfg_err_q, cfg_err_d;

  logic [CNT_W-1:0] cnt_inc;
  logic             cfg_ok;

  // Saturating increment; all interval comparisons use the post-tick value.
  assign cnt_inc = (&cnt_q) ? cnt_q : cnt_q + CNT_W'(1);
  assign cfg_ok  = (CFG_PW != '0) && (CFG_PW < CFG_VRP) && (CFG_VRP < CFG_LRI);

  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    lri_d        = lri_q;
    vrp_d        = vrp_q;
    pw_d         = pw_q;
    sensed_d     = 1'b0;
    pace_start_d = 1'b0;
    cfg_err_d    = cfg_err_q;

    if (CFG_WE) begin
      if (state_q == ST_IDLE && cfg_ok) begin
        lri_d     = CFG_LRI;
        vrp_d     = CFG_VRP;
        pw_d      = CFG_PW;
        cfg_err_d = 1'b0;
      end else begin
        cfg_err_d = 1'b1;
      end
    end

    if (!EN) begin
      state_d = ST_IDLE;
      cnt_d   = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_ALERT;
          cnt_d   = '0;
        end
        ST_ALERT: begin
          // Sense has priority over a coincident expiry tick.
          if (SENSE) begin
            state_d  = ST_REFRACT;
            cnt_d    = '0;
            sensed_d = 1'b1;
          end else if (TICK) begin
            if (cnt_inc == lri_q) begin
              state_d      = ST_PACING;
              cnt_d        = '0;
              pace_start_d = 1'b1;
            end else begin
              cnt_d = cnt_inc;
            end
          end
        end
        ST_PACING: begin
          // cnt keeps running from the pace onset so VRP and LRI share one origin.
          if (TICK) begin
            cnt_d = cnt_inc;
            if (cnt_inc == pw_q) begin
              state_d = ST_REFRACT;
            end
          end
        end
        ST_REFRACT: begin
          if (TICK) begin
            cnt_d = cnt_inc;
            if (cnt_inc == vrp_q) begin
              state_d = ST_ALERT;
            end
          end
        end
        default: begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end
      endcase
    end
  end

  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q      <= ST_IDLE;
      cnt_q        <= '0;
      lri_q        <= CNT_W'(LRI_DEF);
      vrp_q        <= CNT_W'(VRP_DEF);
      pw_q         <= CNT_W'(PW_DEF);
      sensed_q     <= 1'b0;
      pace_start_q <= 1'b0;
      cfg_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      cnt_q        <= cnt_d;
      lri_q        <= lri_d;
      vrp_q        <= vrp_d;
      pw_q         <= pw_d;
      sensed_q     <= sensed_d;
      pace_start_q <= pace_start_d;
      cfg_err_q    <= cfg_err_d;
    end
  end

  // PACE is decoded straight from the state flop so the async reset drops it at once.
  assign PACE    = (state_q == ST_PACING);
  assign SENSED  = sensed_q;
  assign STATE   = state_q;
  assign CFG_ERR = cfg_err_q;

  led_stretch #(.CNT_W(CNT_W), .HOLD(HOLD)) u_led_heart (
    .clk  (CLK),
    .rst  (RST),
    .tick (TICK),
    .trig (sensed_q),
    .led  (LED_HEART)
  );

  led_stretch #(.CNT_W(CNT_W), .HOLD(HOLD)) u_led_pace (
    .clk  (CLK),
    .rst  (RST),
    .tick (TICK),
    .trig (pace_start_q),
    .led  (LED_PACE)
  );

endmodule

// File: tb/tb_pace_timing_ctrl.sv
module tb_pace_timing_ctrl;

  localparam int CNT_W = 16;
  localparam int HOLD  = 3;

  logic             CLK, RST, TICK, EN, SENSE, CFG_WE;
  logic [CNT_W-1:0] CFG_LRI, CFG_VRP, CFG_PW;
  logic             PACE, SENSED, LED_HEART, LED_PACE, CFG_ERR;
  logic [1:0]       STATE;

  int n_checks = 0;
  int n_errors = 0;
  int cyc      = 0;
  int ntick    = 0;
  int tph      = 0;

  // Behavioural model: state is derived from the kind of the last event and ticks elapsed since it.
  bit m_idle   = 1'b1;
  int m_kind   = 0;      // 0 none (fresh entry), 1 sense, 2 pace
  int m_t      = 0;
  int m_lri    = 1000;
  int m_vrp    = 250;
  int m_pw     = 2;
  bit m_err    = 1'b0;
  bit m_sensed = 1'b0;
  bit m_pstart = 1'b0;
  bit hb_has = 1'b0, pc_has = 1'b0;
  int hb_n = 0, pc_n = 0;

  pace_timing_ctrl #(.CNT_W(CNT_W), .HOLD(HOLD)) dut (
    .CLK(CLK), .RST(RST), .TICK(TICK), .EN(EN), .SENSE(SENSE),
    .CFG_WE(CFG_WE), .CFG_LRI(CFG_LRI), .CFG_VRP(CFG_VRP), .CFG_PW(CFG_PW),
    .PACE(PACE), .SENSED(SENSED), .LED_HEART(LED_HEART), .LED_PACE(LED_PACE),
    .STATE(STATE), .CFG_ERR(CFG_ERR)
  );

  initial begin
    CLK = 1'b0;
    forever #5 CLK = ~CLK;
  end

  initial begin
    TICK = 1'b0;
    forever begin
      @(negedge CLK);
      TICK = (tph == 3);
      tph  = (tph + 1) % 4;
    end
  end

  initial forever begin
    @(posedge CLK);
    cyc++;
    if (TICK) ntick++;
  end

  function automatic int mstate();
    if (m_idle) return 0;
    if (m_kind == 2 && m_t < m_pw) return 2;
    if (m_kind != 0 && m_t < m_vrp) return 3;
    return 1;
  endfunction

  task automatic model_reset();
    m_idle = 1'b1; m_kind = 0; m_t = 0;
    m_lri = 1000; m_vrp = 250; m_pw = 2; m_err = 1'b0;
    m_sensed = 1'b0; m_pstart = 1'b0;
    hb_has = 1'b0; pc_has = 1'b0; hb_n = 0; pc_n = 0;
  endtask

  task automatic model_step();
    int st, lw, vw, pw;
    st = mstate();
    if (m_sensed) begin hb_has = 1'b1; hb_n = 0; end
    else if (TICK && hb_n < HOLD) hb_n++;
    if (m_pstart) begin pc_has = 1'b1; pc_n = 0; end
    else if (TICK && pc_n < HOLD) pc_n++;
    if (CFG_WE) begin
      lw = int'(CFG_LRI); vw = int'(CFG_VRP); pw = int'(CFG_PW);
      if (st == 0 && pw != 0 && pw < vw && vw < lw) begin
        m_lri = lw; m_vrp = vw; m_pw = pw; m_err = 1'b0;
      end else begin
        m_err = 1'b1;
      end
    end
    m_sensed = 1'b0;
    m_pstart = 1'b0;
    if (!EN) begin
      m_idle = 1'b1; m_t = 0;
    end else if (st == 0) begin
      m_idle = 1'b0; m_kind = 0; m_t = 0;
    end else if (st == 1 && SENSE) begin
      m_kind = 1; m_t = 0; m_sensed = 1'b1;
    end else if (st == 1 && TICK && m_t + 1 == m_lri) begin
      m_kind = 2; m_t = 0; m_pstart = 1'b1;
    end else if (TICK && m_t < 65535) begin
      m_t++;
    end
  endtask

  initial forever begin
    @(posedge CLK or posedge RST);
    if (RST) model_reset();
    else model_step();
  end

  task automatic chk(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d expected=%0d cycle=%0d", name, act, exp, cyc);
    end
  endtask

  // Every-cycle comparison of the DUT against the model.
  initial forever begin
    int st;
    @(negedge CLK);
    st = mstate();
    chk("STATE", int'(STATE), st);
    chk("PACE", int'(PACE), int'(st == 2));
    chk("SENSED", int'(SENSED), int'(m_sensed));
    chk("LED_HEART", int'(LED_HEART), int'(hb_has && hb_n < HOLD));
    chk("LED_PACE", int'(LED_PACE), int'(pc_has && pc_n < HOLD));
    chk("CFG_ERR", int'(CFG_ERR), int'(m_err));
  end

  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  task automatic cfg_write(input int lri, input int vrp, input int pw);
    CFG_LRI = CNT_W'(lri); CFG_VRP = CNT_W'(vrp); CFG_PW = CNT_W'(pw);
    CFG_WE  = 1'b1;
    step();
    CFG_WE  = 1'b0;
    @(negedge CLK);
  endtask

  // Waits (at negedges) for a DUT output to reach a level; returns tick and cycle counts there.
  task automatic wait_for(input string name, input int idx, input int val, input int bound,
                          output int tk, output int cy);
    int v;
    tk = -1; cy = -1;
    for (int i = 0; i < bound; i++) begin
      @(negedge CLK);
      case (idx)
        0:       v = int'(PACE);
        1:       v = int'(STATE);
        2:       v = int'(LED_PACE);
        default: v = int'(SENSED);
      endcase
      if (v == val) begin
        tk = ntick; cy = cyc;
        return;
      end
    end
    n_checks++; n_errors++;
    $display("FAIL %s timeout actual=not_seen required=%0d within %0d cycles", name, val, bound);
  endtask

  // Steps until n ticks have passed since base; with next_tick, also until the next edge carries a TICK.
  task automatic wait_ticks(input string name, input int base, input int n, input bit next_tick);
    for (int i = 0; i < 400; i++) begin
      step();
      if (ntick - base == n && (!next_tick || tph == 3)) return;
    end
    n_checks++; n_errors++;
    $display("FAIL %s timeout actual=%0d required=%0d ticks", name, ntick - base, n);
  endtask

  task automatic rand_cfg();
    int pw, vrp, lri;
    pw  = $urandom_range(1, 3);
    vrp = pw + $urandom_range(1, 4);
    lri = vrp + $urandom_range(1, 10);
    cfg_write(lri, vrp, pw);
  endtask

  initial begin
    #3000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int t0, t1, t2, t3, t4, ts, tx, c0, c1, c2, c3, c4;
    RST = 1'b1; EN = 1'b0; SENSE = 1'b0; CFG_WE = 1'b0;
    CFG_LRI = '0; CFG_VRP = '0; CFG_PW = '0;
    repeat (3) @(posedge CLK);
    #1 RST = 1'b0;
    @(negedge CLK);
    chk("reset_state", int'(STATE), 0);
    chk("reset_pace", int'(PACE), 0);
    chk("reset_cfg_err", int'(CFG_ERR), 0);
    chk("reset_led_pace", int'(LED_PACE), 0);

    // 1: free-running pacing
    cfg_write(10, 4, 2);
    chk("s1_cfg_err", int'(CFG_ERR), 0);
    EN = 1'b1;
    wait_for("s1_entry", 1, 1, 10, t0, c0);
    wait_for("s1_pace1", 0, 1, 200, t1, c1);
    chk("s1_first_onset_ticks", t1 - t0, 10);
    wait_for("s1_pace1_fall", 0, 0, 100, tx, c2);
    chk("s1_pace_width_cycles", c2 - c1, 8);
    wait_for("s1_ledp_fall", 2, 0, 100, tx, c3);
    chk("s1_led_pace_cycles", c3 - c1 - 1, 11);
    wait_for("s1_pace2", 0, 1, 200, t2, c4);
    chk("s1_period_cycles", c4 - c1, 40);
    chk("s1_period_ticks", t2 - t1, 10);

    // 2: sense at tick 6 inhibits and restarts the escape interval
    wait_ticks("s2_align", t2, 6, 1'b0);
    SENSE = 1'b1; step(); SENSE = 1'b0;
    @(negedge CLK);
    chk("s2_sensed", int'(SENSED), 1);
    chk("s2_state", int'(STATE), 3);
    ts = ntick;
    @(negedge CLK);
    chk("s2_led_heart", int'(LED_HEART), 1);
    wait_for("s2_pace", 0, 1, 200, t3, tx);
    chk("s2_onset_after_sense", t3 - ts, 10);
    chk("s2_onset_after_prev", t3 - t2, 16);

    // 3: sense in refractory is ignored
    wait_ticks("s3_align", t3, 2, 1'b0);
    SENSE = 1'b1; step(); SENSE = 1'b0;
    @(negedge CLK);
    chk("s3_no_sensed", int'(SENSED), 0);
    chk("s3_state", int'(STATE), 3);
    @(negedge CLK);
    chk("s3_led_heart", int'(LED_HEART), 0);
    wait_for("s3_pace", 0, 1, 200, t4, tx);
    chk("s3_period_ticks", t4 - t3, 10);

    // 4: sense coincident with the expiry tick wins
    wait_ticks("s4_align", t4, 9, 1'b1);
    SENSE = 1'b1; step(); SENSE = 1'b0;
    @(negedge CLK);
    chk("s4_sensed", int'(SENSED), 1);
    chk("s4_no_pace", int'(PACE), 0);
    chk("s4_state", int'(STATE), 3);

    // 5: config writes
    EN = 1'b0; step();
    cfg_write(10, 4, 2);
    chk("s5_good_err", int'(CFG_ERR), 0);
    cfg_write(3, 4, 2);
    chk("s5_reject_err", int'(CFG_ERR), 1);
    EN = 1'b1;
    wait_for("s5_entry", 1, 1, 10, t0, tx);
    wait_for("s5_pace", 0, 1, 200, t1, tx);
    chk("s5_retained_ticks", t1 - t0, 10);
    EN = 1'b0; step();
    cfg_write(10, 4, 2);
    chk("s5_clear_err", int'(CFG_ERR), 0);
    EN = 1'b1;
    wait_for("s5_entry2", 1, 1, 10, t0, tx);
    cfg_write(20, 5, 2);
    chk("s5_alert_write_err", int'(CFG_ERR), 1);
    wait_for("s5_pace2", 0, 1, 200, t1, tx);
    chk("s5_ignored_ticks", t1 - t0, 10);

    // 6: EN drop and async reset mid-pulse
    EN = 1'b0;
    chk("s6_pace_before_edge", int'(PACE), 1);
    step();
    chk("s6_en_pace", int'(PACE), 0);
    chk("s6_en_state", int'(STATE), 0);
    EN = 1'b1;
    wait_for("s6_entry", 1, 1, 10, t0, tx);
    wait_for("s6_pace", 0, 1, 200, t1, tx);
    #1 RST = 1'b1;
    #1;
    chk("s6_rst_pace", int'(PACE), 0);
    chk("s6_rst_state", int'(STATE), 0);
    EN = 1'b0;
    step(); step();
    RST = 1'b0;
    @(negedge CLK);
    chk("s6_rst_cfg_err", int'(CFG_ERR), 0);
    EN = 1'b1;
    wait_for("s6_entry2", 1, 1, 10, t0, tx);
    wait_for("s6_default_pace", 0, 1, 4200, t1, tx);
    chk("s6_default_lri_ticks", t1 - t0, 1000);

    // Randomized traffic against the model
    EN = 1'b0; step();
    rand_cfg();
    EN = 1'b1;
    for (int i = 0; i < 3000; i++) begin
      step();
      SENSE  = ($urandom_range(0, 11) == 0);
      CFG_WE = ($urandom_range(0, 199) == 0);
      CFG_LRI = CNT_W'($urandom_range(0, 15));
      CFG_VRP = CNT_W'($urandom_range(0, 15));
      CFG_PW  = CNT_W'($urandom_range(0, 15));
      EN = ($urandom_range(0, 299) != 0);
      if ($urandom_range(0, 399) == 0) begin
        SENSE = 1'b0; CFG_WE = 1'b0; EN = 1'b0;
        step();
        rand_cfg();
        EN = 1'b1;
      end
    end
    SENSE = 1'b0; CFG_WE = 1'b0;
    repeat (20) step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
